// File: rtl/imem_ctrl_pkg.sv
// Shared types and helpers for the instruction-memory boot loader / arbiter.
package imem_ctrl_pkg;

    localparam int DEFAULT_ADDR_W = 14;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_LOAD,
        ST_RUN,
        ST_ERR
    } state_e;

    // Byte address to word address; callers truncate to their ADDR_W, which wraps.
    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/rx_word_packer.sv
// Byte-stream handshake that assembles little-endian 32-bit words.
module rx_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        accept_en_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] buf_q, buf_d;
    logic        fire;

    assign rx_ready_o   = accept_en_i && !rst;
    assign fire         = rx_valid_i && rx_ready_o;
    assign word_valid_o = fire && (byte_cnt_q == 2'd3);
    // The 4th byte is forwarded straight through so the word is usable on its handshake.
    assign word_o       = {rx_data_i, buf_q};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
        if (fire) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    buf_d[7:0]   = rx_data_i;
                2'd1:    buf_d[15:8]  = rx_data_i;
                2'd2:    buf_d[23:16] = rx_data_i;
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q <= '0;
            buf_q      <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction BRAM boot loader (byte-stream program load) and fetch/data read-port arbiter.
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              core_run,
    output logic              load_err,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_grant,
    output logic              fetch_valid,
    output logic [31:0]       fetch_rdata,
    input  logic              d_req,
    input  logic [31:0]       d_addr,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned   MAX_WORDS = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                core_run_q, load_err_q;
    logic                last_d_q, last_fetch_denied_q;
    logic                fetch_valid_q, d_rvalid_q;

    logic                accept_en, word_valid, run;
    logic [31:0]         rx_word;

    assign accept_en = (state_q == ST_HDR) || (state_q == ST_LOAD);
    assign run       = (state_q == ST_RUN);

    rx_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .accept_en_i  (accept_en),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .rx_ready_o   (rx_ready),
        .word_valid_o (word_valid),
        .word_o       (rx_word)
    );

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        n_d        = n_q;
        wr_addr_d  = wr_addr_q;
        wdata_d    = wdata_q;
        mem_we_d   = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (word_valid) begin
                    word_cnt_d = '0;
                    if (rx_word == 32'd0) begin
                        state_d = ST_RUN;
                    end else if (rx_word > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        n_d     = rx_word[ADDR_W:0];
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    mem_we_d   = 1'b1;
                    wr_addr_d  = word_cnt_q[ADDR_W-1:0];
                    wdata_d    = rx_word;
                    word_cnt_d = word_cnt_q + CNT_ONE;
                end else if (mem_we_q && (word_cnt_q == n_q)) begin
                    // Leave only after the last write has been presented to the BRAM.
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    // Data wins unless it won last cycle while fetch was refused, so fetch never waits twice.
    assign d_ready     = run && d_req && !(last_d_q && last_fetch_denied_q);
    assign fetch_grant = run && fetch_req && !d_ready;

    always_comb begin
        mem_addr = '0;
        if (state_q == ST_LOAD) begin
            mem_addr = wr_addr_q;
        end else if (run) begin
            mem_addr = d_ready ? ADDR_W'(byte_to_word(d_addr))
                               : ADDR_W'(byte_to_word(fetch_addr));
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_wdata   = wdata_q;
    assign core_run    = core_run_q;
    assign load_err    = load_err_q;
    assign fetch_valid = fetch_valid_q;
    assign d_rvalid    = d_rvalid_q;
    assign fetch_rdata = mem_rdata;
    assign d_rdata     = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= ST_HDR;
            word_cnt_q          <= '0;
            n_q                 <= '0;
            wr_addr_q           <= '0;
            wdata_q             <= '0;
            mem_we_q            <= 1'b0;
            core_run_q          <= 1'b0;
            load_err_q          <= 1'b0;
            last_d_q            <= 1'b0;
            last_fetch_denied_q <= 1'b0;
            fetch_valid_q       <= 1'b0;
            d_rvalid_q          <= 1'b0;
        end else begin
            state_q             <= state_d;
            word_cnt_q          <= word_cnt_d;
            n_q                 <= n_d;
            wr_addr_q           <= wr_addr_d;
            wdata_q             <= wdata_d;
            mem_we_q            <= mem_we_d;
            core_run_q          <= (state_d == ST_RUN);
            load_err_q          <= (state_d == ST_ERR);
            last_d_q            <= d_ready;
            last_fetch_denied_q <= run && fetch_req && !fetch_grant;
            fetch_valid_q       <= fetch_grant;
            d_rvalid_q          <= d_ready;
        end
    end

endmodule
